// File: rtl/pdm_pkg.sv
// Shared types and helpers for the packet data mover: FSM state encodings,
// default FIFO sizing and the FIFO space test used by the ingress drop check.
package pdm_pkg;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_LEN  = 2'd1,
    I_PAY  = 2'd2
  } ingress_state_t;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_OFFER = 2'd1,
    E_SEND  = 2'd2
  } egress_state_t;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  // A packet needs its payload plus one length word of free space.
  function automatic logic fits(input logic [15:0] free, input logic [15:0] len);
    return (free > len);
  endfunction

endpackage

// File: rtl/pdm_port_fifo.sv
// Per-port first-word-fall-through FIFO holding length words and payload.
// Simultaneous read and write are allowed; callers never overflow or underflow it.
module pdm_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     free_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign free_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/pdm_router.sv
// Packet data mover: one framed ingress stream fanned out (with multicast) into
// per-port FIFOs, each drained by an independent offer/proceed/send egress FSM.
module pdm_router
  import pdm_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        bnd_plse,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        ack,
  output logic                        drop,
  output logic [N_PORTS*DATA_W-1:0]   newdata_len,
  input  logic [N_PORTS-1:0]          proceed,
  output logic [N_PORTS*DATA_W-1:0]   data_out,
  output logic [N_PORTS-1:0]          data_vld
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W:0] MAX_LEN = (DATA_W+1)'(FIFO_DEPTH - 1);

  ingress_state_t     ist_q;
  logic [N_PORTS-1:0] mask_q;
  logic [DATA_W-1:0]  rem_q;
  logic               drop_flag_q;
  logic               ack_q;
  logic               drop_q;

  logic               space_ok_s;
  logic               drop_now_s;
  logic               last_pay_s;
  logic [N_PORTS-1:0] wr_en_s;
  logic [N_PORTS-1:0] rd_en_s;
  logic [N_PORTS-1:0] pkt_inc_s;
  logic [DATA_W-1:0]  fifo_dout_s [N_PORTS];
  logic [FCW-1:0]     fifo_cnt_s  [N_PORTS];
  logic [FCW-1:0]     fifo_free_s [N_PORTS];

  // The space check uses free space before any same-cycle egress pop, so it is conservative.
  always_comb begin
    space_ok_s = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      if (mask_q[p] && !fits(16'(fifo_free_s[p]), 16'(data_in))) space_ok_s = 1'b0;
      else space_ok_s = space_ok_s;
    end
  end

  assign drop_now_s = (mask_q == {N_PORTS{1'b0}}) || (data_in == {DATA_W{1'b0}}) ||
                      ({1'b0, data_in} > MAX_LEN) || !space_ok_s;
  assign last_pay_s = (ist_q == I_PAY) && (rem_q == DATA_W'(1));

  always_comb begin
    wr_en_s   = {N_PORTS{1'b0}};
    pkt_inc_s = {N_PORTS{1'b0}};
    for (int p = 0; p < N_PORTS; p++) begin
      wr_en_s[p]   = mask_q[p] && (((ist_q == I_LEN) && !drop_now_s) ||
                                   ((ist_q == I_PAY) && !drop_flag_q));
      pkt_inc_s[p] = mask_q[p] && last_pay_s && !drop_flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ist_q       <= I_IDLE;
      mask_q      <= {N_PORTS{1'b0}};
      rem_q       <= {DATA_W{1'b0}};
      drop_flag_q <= 1'b0;
      ack_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      case (ist_q)
        I_IDLE: begin
          if (bnd_plse) begin
            mask_q <= data_in[N_PORTS-1:0];
            ist_q  <= I_LEN;
          end
        end
        I_LEN: begin
          drop_flag_q <= drop_now_s;
          rem_q       <= data_in;
          if (data_in == {DATA_W{1'b0}}) begin
            ack_q  <= 1'b1;
            drop_q <= 1'b1;
            ist_q  <= I_IDLE;
          end else begin
            ist_q <= I_PAY;
          end
        end
        I_PAY: begin
          rem_q <= rem_q - DATA_W'(1);
          if (last_pay_s) begin
            ack_q  <= 1'b1;
            drop_q <= drop_flag_q;
            ist_q  <= I_IDLE;
          end
        end
        default: ist_q <= I_IDLE;
      endcase
    end
  end

  assign ack  = ack_q;
  assign drop = drop_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    egress_state_t     est_q;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic [FCW-1:0]    pkt_cnt_q;
    logic              pop_len_s;

    pdm_port_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .wr_en_i (wr_en_s[p]),
      .din_i   (data_in),
      .rd_en_i (rd_en_s[p]),
      .dout_o  (fifo_dout_s[p]),
      .count_o (fifo_cnt_s[p]),
      .free_o  (fifo_free_s[p])
    );

    // pkt_cnt only counts fully written packets, so a popped length always has its payload behind it.
    assign pop_len_s  = (est_q == E_IDLE) && (pkt_cnt_q != {FCW{1'b0}}) &&
                        (fifo_cnt_s[p] != {FCW{1'b0}});
    assign rd_en_s[p] = pop_len_s || ((est_q == E_OFFER) && proceed[p]) ||
                        ((est_q == E_SEND) && (cnt_q != {DATA_W{1'b0}}));

    always_ff @(posedge clk) begin
      if (!rst_b) begin
        est_q     <= E_IDLE;
        len_q     <= {DATA_W{1'b0}};
        cnt_q     <= {DATA_W{1'b0}};
        dout_q    <= {DATA_W{1'b0}};
        vld_q     <= 1'b0;
        pkt_cnt_q <= {FCW{1'b0}};
      end else begin
        pkt_cnt_q <= pkt_cnt_q + FCW'(pkt_inc_s[p]) - FCW'(pop_len_s);
        case (est_q)
          E_IDLE: begin
            if (pop_len_s) begin
              len_q <= fifo_dout_s[p];
              est_q <= E_OFFER;
            end
          end
          E_OFFER: begin
            if (proceed[p]) begin
              len_q  <= {DATA_W{1'b0}};
              dout_q <= fifo_dout_s[p];
              vld_q  <= 1'b1;
              cnt_q  <= len_q - DATA_W'(1);
              est_q  <= E_SEND;
            end
          end
          E_SEND: begin
            if (cnt_q != {DATA_W{1'b0}}) begin
              dout_q <= fifo_dout_s[p];
              cnt_q  <= cnt_q - DATA_W'(1);
            end else begin
              vld_q <= 1'b0;
              est_q <= E_IDLE;
            end
          end
          default: begin
            vld_q <= 1'b0;
            est_q <= E_IDLE;
          end
        endcase
      end
    end

    assign newdata_len[p*DATA_W +: DATA_W] = len_q;
    assign data_out[p*DATA_W +: DATA_W]    = dout_q;
    assign data_vld[p]                     = vld_q;
  end

endmodule

// File: tb/tb_pdm_router.sv
// Directed-sequence bench with random payloads; a queue-based model predicts
// accept/drop from free space and the in-order words each port must deliver.
module tb_pdm_router;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int FD = 16;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             bnd_plse;
  logic [DW-1:0]    data_in;
  logic             ack;
  logic             drop;
  logic [NP*DW-1:0] newdata_len;
  logic [NP-1:0]    proceed;
  logic [NP*DW-1:0] data_out;
  logic [NP-1:0]    data_vld;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_len  [NP][$];
  logic [7:0] exp_data [NP][$];
  int         used     [NP];
  logic [7:0] prev_len [NP];
  logic [7:0] pay      [32];

  pdm_router #(.N_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .bnd_plse    (bnd_plse),
    .data_in     (data_in),
    .ack         (ack),
    .drop        (drop),
    .newdata_len (newdata_len),
    .proceed     (proceed),
    .data_out    (data_out),
    .data_vld    (data_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pay();
    for (int i = 0; i < 32; i++) pay[i] = 8'($urandom_range(1, 255));
  endtask

  // Sends one packet, updates the model, and returns at the negedge of the ack cycle.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] len);
    logic [3:0] m;
    logic       acc;
    m   = hdr[3:0];
    acc = (m != 4'd0) && (len != 8'd0) && (int'(len) <= FD - 1);
    for (int p = 0; p < NP; p++)
      if (m[p] && ((FD - used[p]) <= int'(len))) acc = 1'b0;
    bnd_plse = 1'b1; data_in = hdr; step();
    bnd_plse = 1'b0; data_in = len; step();
    for (int i = 0; i < int'(len); i++) begin
      data_in = pay[i];
      step();
    end
    data_in = 8'd0;
    if (acc) begin
      for (int p = 0; p < NP; p++) begin
        if (m[p]) begin
          exp_len[p].push_back(len);
          for (int i = 0; i < int'(len); i++) exp_data[p].push_back(pay[i]);
          used[p] += int'(len) + 1;
        end
      end
    end
    @(negedge clk);
    check("ack", 32'(ack), 32'd1);
    check("drop", 32'(drop), 32'(!acc));
  endtask

  // Egress monitor: every new offer and every valid word must match the model in order.
  initial begin
    logic [7:0] cur;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int p = 0; p < NP; p++) begin
          cur = newdata_len[p*DW +: DW];
          if ((cur != 8'd0) && (prev_len[p] == 8'd0)) begin
            if (exp_len[p].size() > 0) begin
              check($sformatf("offer_p%0d", p), 32'(cur), 32'(exp_len[p].pop_front()));
              used[p]--;
            end else begin
              check($sformatf("unexp_offer_p%0d", p), 32'(cur), 32'd0);
            end
          end
          prev_len[p] = cur;
          if (data_vld[p]) begin
            if (exp_data[p].size() > 0) begin
              check($sformatf("word_p%0d", p), 32'(data_out[p*DW +: DW]), 32'(exp_data[p].pop_front()));
              used[p]--;
            end else begin
              check($sformatf("unexp_vld_p%0d", p), 32'(data_vld[p]), 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    int         offs [NP];
    logic [7:0] hdr;
    logic [31:0] exp_vec;
    offs = '{0, 3, 5, 9};
    for (int p = 0; p < NP; p++) begin
      used[p]     = 0;
      prev_len[p] = 8'd0;
    end
    rst_b = 1'b0; bnd_plse = 1'b0; data_in = 8'd0; proceed = 4'd0;
    repeat (3) step();
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_len", newdata_len, 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_vld", 32'(data_vld), 32'd0);
    rst_b = 1'b1;
    mon_en = 1'b1;
    step();

    // Unicast to port 1 with random upper header bits.
    fill_pay();
    hdr = {4'($urandom), 4'h2};
    send_pkt(hdr, 8'd3);
    step();
    @(negedge clk);
    check("uni_ack_low", 32'(ack), 32'd0);
    exp_vec = 32'd0;
    exp_vec[15:8] = 8'd3;
    check("uni_offer_t2", newdata_len, exp_vec);
    proceed[1] = 1'b1;
    step();
    proceed[1] = 1'b0;
    @(negedge clk);
    check("uni_vld_first", 32'(data_vld), 32'h2);
    check("uni_word0", 32'(data_out[15:8]), 32'(pay[0]));
    check("uni_len_clr", newdata_len, 32'd0);
    repeat (5) step();

    // Multicast with staggered proceeds.
    fill_pay();
    send_pkt(8'h0F, 8'd2);
    step();
    @(negedge clk);
    check("mc_offer_all", newdata_len, 32'h02020202);
    for (int k = 0; k <= 10; k++) begin
      for (int p = 0; p < NP; p++) proceed[p] = (offs[p] == k);
      step();
      proceed = 4'd0;
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (offs[p] == k) check($sformatf("mc_vld_start_p%0d", p), 32'(data_vld[p]), 32'd1);
        if (offs[p] > k) begin
          check($sformatf("mc_hold_p%0d", p), 32'(newdata_len[p*DW +: DW]), 32'd2);
          check($sformatf("mc_wait_p%0d", p), 32'(data_vld[p]), 32'd0);
        end
      end
    end
    repeat (4) step();

    // Drops: empty mask, zero length, oversize length.
    fill_pay();
    send_pkt(8'h00, 8'd2);
    step();
    send_pkt({4'($urandom), 4'h3}, 8'd0);
    step();
    send_pkt(8'h01, 8'd16);
    step();
    @(negedge clk);
    check("drop_ack_low", 32'(ack), 32'd0);
    repeat (4) step();
    @(negedge clk);
    check("drop_no_offer", newdata_len, 32'd0);
    check("drop_no_vld", 32'(data_vld), 32'd0);

    // Backpressure on port 0: model decides which packets fit.
    for (int i = 0; i < 4; i++) begin
      fill_pay();
      send_pkt(8'h01, 8'd4);
      step();
    end
    fill_pay();
    send_pkt(8'h02, 8'd4);
    step();
    proceed[1] = 1'b1;
    repeat (10) step();
    proceed[1] = 1'b0;

    // Back-to-back single-word packets to port 2 with proceed held high.
    proceed[2] = 1'b1;
    fill_pay();
    send_pkt(8'h04, 8'd1);
    step();
    fill_pay();
    send_pkt(8'h04, 8'd1);
    step();
    repeat (8) step();
    proceed = 4'hF;
    repeat (40) step();
    proceed = 4'd0;
    step();

    // Reset in the middle of a payload.
    bnd_plse = 1'b1; data_in = 8'h08; step();
    bnd_plse = 1'b0; data_in = 8'd5; step();
    data_in = 8'($urandom_range(1, 255)); step();
    data_in = 8'($urandom_range(1, 255));
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    data_in = 8'd0;
    @(negedge clk);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_len", newdata_len, 32'd0);
    check("mid_rst_dout", data_out, 32'd0);
    check("mid_rst_vld", 32'(data_vld), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      check("mid_rst_no_ack", 32'(ack), 32'd0);
    end
    step();
    fill_pay();
    send_pkt(8'h08, 8'd2);
    step();
    proceed[3] = 1'b1;
    repeat (8) step();
    proceed = 4'd0;
    step();

    for (int p = 0; p < NP; p++) begin
      check($sformatf("left_len_p%0d", p), 32'(exp_len[p].size()), 32'd0);
      check($sformatf("left_data_p%0d", p), 32'(exp_data[p].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
